muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have req_valid, input, 1, EXE-stage multiply/divide request present.
REQ-004 SHALL have req_ready, output, 1, controller accepts request this cycle.
REQ-005 SHALL have req_op, input, 2, operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have req_src1, input, 32, rs operand (multiplicand/dividend).
REQ-007 SHALL have req_src2, input, 32, rt operand (multiplier/divisor).
REQ-008 SHALL have flush, input, 1, abandon any in-flight or pending operation.
REQ-009 SHALL have res_valid, output, 1, HI/LO result available.
REQ-010 SHALL have res_ready, input, 1, consumer (HI/LO write path) takes result.
REQ-011 SHALL have res_hi, output, 32, HI result (product high word / remainder).
REQ-012 SHALL have res_lo, output, 32, LO result (product low word / quotient).
REQ-013 SHALL have busy, output, 1, asserted whenever state is not IDLE; used by ID stage to stall mfhi/mflo.
REQ-014 SHALL have div_by_zero, output, 1, qualifies res_valid; set for div/divu with req_src2 == 0.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-016 SHALL drive req_ready = 1 only in IDLE with flush = 0; acceptance = req_valid & req_ready.
REQ-017 SHALL on acceptance latch req_op, req_src1, req_src2; go to MUL for op 0x, to DIV for op 1x with nonzero divisor, to DONE for zero divisor.
REQ-018 SHALL in MUL compute 64-bit product (signed for mult, unsigned for multu) in one cycle, go to DONE; res_valid first high at accept cycle + 2.
REQ-019 SHALL in DIV perform restoring radix-2 division on operand magnitudes, one quotient bit per cycle, 5-bit counter 0..31; after counter 31 go to DONE; res_valid first high at accept cycle + 33.
REQ-020 SHALL for div set quotient sign = src1[31] ^ src2[31], remainder sign = src1[31]; divu uses raw operands.
REQ-021 SHALL for 0x80000000 / 0xFFFFFFFF (div) yield lo = 0x80000000, hi = 0x00000000.
REQ-022 SHALL for zero divisor yield hi = src1, lo = 0xFFFFFFFF, div_by_zero = 1, res_valid at accept + 2 (one dummy cycle through DONE path).
REQ-023 SHALL in DONE hold res_valid = 1 and res_hi/res_lo/div_by_zero stable until res_ready = 1, then go to IDLE next cycle.
REQ-024 SHALL not accept a new request in the cycle res_ready completes (req_ready low in DONE).
REQ-025 SHALL on flush = 1 in any state go to IDLE next cycle, discard result, never assert res_valid for that operation; flush wins over simultaneous req_valid or res_ready.
REQ-026 SHALL drive res_valid = 0 outside DONE; res_hi/res_lo values outside DONE are don't-care.

Reset
REQ-027 SHALL on reset enter IDLE, clear counter, res_valid = 0, busy = 0, div_by_zero = 0, res_hi = res_lo = 0; reset mid-operation aborts identically to flush.

Structure
REQ-028 SHALL take req_op encodings and FSM state encodings from the shared header mycpu.h, alongside existing bus-width defines.
REQ-029 SHALL place the iterative magnitude divider (partial remainder, quotient shift register, counter) in sub-module div_iter, with start/done ports; FSM, multiplier, sign fix-up stay in muldiv_ctrl.

Verification
REQ-030 SHALL cover multu 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001, res_valid at accept + 2.
REQ-031 SHALL cover mult 0xFFFFFFFD (-3) x 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
REQ-032 SHALL cover div 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, res_valid at accept + 33, busy high cycles accept+1..done.
REQ-033 SHALL cover divu 0x64 / 0 -> div_by_zero = 1, hi = 0x64, lo = 0xFFFFFFFF at accept + 2.
REQ-034 SHALL cover flush at DIV counter 10 -> IDLE next cycle, req_ready = 1, no res_valid; following divu 9/4 -> lo = 2, hi = 1.
REQ-035 SHALL cover res_ready low 5 cycles in DONE -> outputs stable, req_ready = 0; res_ready high -> IDLE next cycle.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide controller.
package muldiv_ctrl_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;

   // req_op encodings as seen on the EXE-stage request bus
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   // Controller FSM states
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10,
      S_DONE = 2'b11
   } state_e;

   // Two's-complement negate when neg is set, pass-through otherwise
   function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] x);
      return neg ? (~x + XLEN'(1)) : x;
   endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 magnitude divider: one quotient bit per cycle, 32 cycles.
module div_iter
   import muldiv_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [XLEN-1:0] dvd_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic            done_c_o,
   output logic [XLEN-1:0] quo_c_o,
   output logic [XLEN-1:0] rem_c_o
);

   logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;

   logic [XLEN:0]    shift_c, diff_c;
   logic [XLEN-1:0]  rem_d, quo_d;

   // One restoring step: shift in next dividend bit, subtract if it fits
   always_comb begin
      shift_c = {rem_q, quo_q[XLEN-1]};
      diff_c  = shift_c - {1'b0, dvs_q};
      if (!diff_c[XLEN]) begin
         rem_d = diff_c[XLEN-1:0];
         quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
         rem_d = shift_c[XLEN-1:0];
         quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
   end

   assign done_c_o = run_q && (cnt_q == CNT_W'(XLEN - 1));
   assign quo_c_o  = quo_d;
   assign rem_c_o  = rem_d;

   // Iteration registers; the dividend shifts out of the quotient register
   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (abort_i) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start_i) begin
         rem_q <= '0;
         quo_q <= dvd_i;
         dvs_q <= dvs_i;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(XLEN - 1)) begin
            run_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: request/response handshake, single-cycle
// multiplier, iterative divider with sign fix-up, flush and zero-divisor handling.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        flush,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        busy,
   output logic        div_by_zero
);

   state_e          state_q;
   op_e             op_q;
   logic [XLEN-1:0] src1_q, src2_q, res_hi_q, res_lo_q;
   logic            res_valid_q, busy_q, dbz_q;

   op_e             op_in;
   logic            accept_c, div_start_c, div_sgn_c, div_done_c;
   logic [XLEN-1:0] dvd_mag_c, dvs_mag_c, quo_c, rem_c, quo_fix_c, rem_fix_c;
   logic [2*XLEN-1:0] mul_a_c, mul_b_c, prod_c;
   logic            mul_sgn_c, q_neg_c, r_neg_c;

   assign req_ready   = (state_q == S_IDLE) && !flush;
   assign accept_c    = req_valid && req_ready;
   assign op_in       = op_e'(req_op);

   assign res_valid   = res_valid_q;
   assign res_hi      = res_hi_q;
   assign res_lo      = res_lo_q;
   assign busy        = busy_q;
   assign div_by_zero = dbz_q;

   // Divider launch with operand magnitudes taken straight off the request bus
   assign div_sgn_c   = (op_in == OP_DIV);
   assign div_start_c = accept_c && req_op[1] && (req_src2 != '0);
   assign dvd_mag_c   = neg_if(div_sgn_c && req_src1[XLEN-1], req_src1);
   assign dvs_mag_c   = neg_if(div_sgn_c && req_src2[XLEN-1], req_src2);

   div_iter u_div_iter (
      .clk      (clk),
      .reset    (reset),
      .start_i  (div_start_c),
      .abort_i  (flush),
      .dvd_i    (dvd_mag_c),
      .dvs_i    (dvs_mag_c),
      .done_c_o (div_done_c),
      .quo_c_o  (quo_c),
      .rem_c_o  (rem_c)
   );

   // Sign-extend for mult, zero-extend for multu; low 64 bits are exact either way
   assign mul_sgn_c = (op_q == OP_MULT);
   assign mul_a_c   = {{XLEN{mul_sgn_c && src1_q[XLEN-1]}}, src1_q};
   assign mul_b_c   = {{XLEN{mul_sgn_c && src2_q[XLEN-1]}}, src2_q};
   assign prod_c    = mul_a_c * mul_b_c;

   // Signed-divide fix-up: quotient sign from both operands, remainder follows dividend
   assign q_neg_c   = (op_q == OP_DIV) && (src1_q[XLEN-1] ^ src2_q[XLEN-1]);
   assign r_neg_c   = (op_q == OP_DIV) && src1_q[XLEN-1];
   assign quo_fix_c = neg_if(q_neg_c, quo_c);
   assign rem_fix_c = neg_if(r_neg_c, rem_c);

   // Controller FSM with registered result and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_MULT;
         src1_q      <= '0;
         src2_q      <= '0;
         res_hi_q    <= '0;
         res_lo_q    <= '0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else if (flush) begin
         state_q     <= S_IDLE;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q   <= op_in;
                  src1_q <= req_src1;
                  src2_q <= req_src2;
                  busy_q <= 1'b1;
                  dbz_q  <= 1'b0;
                  if (!req_op[1]) begin
                     state_q <= S_MUL;
                  end else if (req_src2 == '0) begin
                     // Result is known now; DONE spends one cycle before presenting it
                     state_q  <= S_DONE;
                     res_hi_q <= req_src1;
                     res_lo_q <= '1;
                     dbz_q    <= 1'b1;
                  end else begin
                     state_q <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               res_hi_q    <= prod_c[2*XLEN-1:XLEN];
               res_lo_q    <= prod_c[XLEN-1:0];
               res_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DIV: begin
               if (div_done_c) begin
                  res_hi_q    <= rem_fix_c;
                  res_lo_q    <= quo_fix_c;
                  res_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (!res_valid_q) begin
                  res_valid_q <= 1'b1;
               end else if (res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  dbz_q       <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
